// File: rtl/mux16_rr_scheduler_pkg.sv
// Shared types and helpers for the 16-way round-robin mux scheduler.
// Imported by the interface, the picker and the top.
package mux16_sched_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot16(
    input logic [SEL_W-1:0] s
  );
    logic [N_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux16_rr_scheduler_if.sv
// Requester-bank / mux-select bundle of the scheduler.
// master drives req, slave (the scheduler) drives the select side.
interface mux16_rr_scheduler_if;
  import mux16_sched_pkg::*;

  logic [N_REQ-1:0] req;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic [N_REQ-1:0] grant;

  modport master (
    output req,
    input  sel,
    input  sel_valid,
    input  grant
  );

  modport slave (
    input  req,
    output sel,
    output sel_valid,
    output grant
  );

endinterface

// File: rtl/mux16_rr_scheduler_rr_pick16.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping 15 -> 0.
module rr_pick16
  import mux16_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // Rotate so ptr lands at bit 0, take lowest set bit, undo rotation.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx = off + ptr;
    any = |req;
  end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin owner of a shared 16:1 mux select with bounded bursts
// and early release; all outputs registered.
module mux16_rr_scheduler
  import mux16_sched_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux16_rr_scheduler_if.slave bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             term;

  rr_pick16 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Burst ends on the last allowed cycle or when the owner lets go.
  assign term = (cnt_q == CNT_W'(BURST_LEN - 1)) | ~bus.req[sel_q];

  // State register plus registered outputs; reset aborts any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      grant_q     <= grant_d;
    end
  end

  // Next state: arbitrate from IDLE or at burst end, else count.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          cnt_d   = '0;
          ptr_d   = pick_idx + SEL_W'(1);
        end
      end
      GRANT: begin
        if (!term) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (pick_any) begin
          sel_d = pick_idx;
          cnt_d = '0;
          ptr_d = pick_idx + SEL_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs for the coming cycle; sel is kept as-is when going idle.
  always_comb begin
    sel_valid_d = (state_d == GRANT);
    grant_d     = sel_valid_d ? onehot16(sel_d) : '0;
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Bench for mux16_rr_scheduler: directed table, corner sequences and
// random traffic against a behavioural round-robin model.
module tb_mux16_rr_scheduler;
  import mux16_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux16_rr_scheduler_if ifa ();
  mux16_rr_scheduler_if ifb ();

  mux16_rr_scheduler #(.BURST_LEN(4), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  mux16_rr_scheduler #(.BURST_LEN(1), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner, cycles used in current grant, next search start.
  bit m_act  [2];
  int m_sel  [2];
  int m_used [2];
  int m_ptr  [2];
  int m_blen [2] = '{4, 1};

  typedef struct {
    logic [15:0] req;
    logic [3:0]  sel;
    logic        vld;
    logic [15:0] gnt;
  } vec_t;
  vec_t tab [10];

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i]  = 1'b0;
      m_sel[i]  = 0;
      m_used[i] = 0;
      m_ptr[i]  = 0;
    end
  endfunction

  function automatic void m_pick(int i, logic [15:0] r);
    for (int k = 0; k < 16; k++) begin
      int j;
      j = (m_ptr[i] + k) % 16;
      if (r[j]) begin
        m_sel[i]  = j;
        m_used[i] = 1;
        m_ptr[i]  = (j + 1) % 16;
        m_act[i]  = 1'b1;
        return;
      end
    end
    m_act[i] = 1'b0;
  endfunction

  function automatic void m_step(int i, logic [15:0] r);
    if (m_act[i] && m_used[i] < m_blen[i] && r[m_sel[i]])
      m_used[i] = m_used[i] + 1;
    else
      m_pick(i, r);
  endfunction

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_a(string nm, logic [3:0] s, logic v,
                       logic [15:0] g);
    chk({nm, ".sel"},   16'(ifa.sel),       16'(s));
    chk({nm, ".valid"}, 16'(ifa.sel_valid), 16'(v));
    chk({nm, ".grant"}, ifa.grant,          g);
  endtask

  task automatic chk_model(int i, string nm);
    logic [15:0] es, ev, eg, gs, gv, gg;
    es = 16'(m_sel[i]);
    ev = 16'(m_act[i]);
    eg = m_act[i] ? (16'(1) << m_sel[i]) : 16'h0;
    if (i == 0) begin
      gs = 16'(ifa.sel); gv = 16'(ifa.sel_valid); gg = ifa.grant;
    end else begin
      gs = 16'(ifb.sel); gv = 16'(ifb.sel_valid); gg = ifb.grant;
    end
    chk({nm, ".sel"},   gs, es);
    chk({nm, ".valid"}, gv, ev);
    chk({nm, ".grant"}, gg, eg);
  endtask

  task automatic step();
    logic [15:0] ra, rb;
    ra = ifa.req;
    rb = ifb.req;
    @(posedge clk);
    m_step(0, ra);
    m_step(1, rb);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  function automatic logic [15:0] rnd_req();
    case ($urandom_range(0, 3))
      0:       return 16'h0;
      1:       return 16'(1) << $urandom_range(0, 15);
      2:       return 16'($urandom & $urandom);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    for (int r = 0; r < 10; r++) begin
      tab[r].req = 16'h8001;
      tab[r].vld = 1'b1;
      tab[r].sel = (r >= 4 && r < 8) ? 4'd15 : 4'd0;
      tab[r].gnt = (r >= 4 && r < 8) ? 16'h8000 : 16'h0001;
    end

    ifa.req = '0;
    ifb.req = '0;
    m_reset();

    #3;
    chk_a("reset_a", 4'd0, 1'b0, 16'h0);
    chk("reset_b.sel",   16'(ifb.sel),       16'h0);
    chk("reset_b.valid", 16'(ifb.sel_valid), 16'h0);
    chk("reset_b.grant", ifb.grant,          16'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 10; r++) begin
      ifa.req = tab[r].req;
      step();
      chk_a($sformatf("t2_row%0d", r), tab[r].sel, tab[r].vld, tab[r].gnt);
    end
    ifa.req = '0;
    do_reset();

    ifa.req = 16'h0020;
    for (int k = 0; k < 9; k++) begin
      step();
      chk_a($sformatf("t1_cyc%0d", k), 4'd5, 1'b1, 16'h0020);
    end
    ifa.req = '0;
    do_reset();

    ifa.req = 16'h0008;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_a($sformatf("t3_cyc%0d", k), 4'd3, 1'b1, 16'h0008);
    end
    ifa.req = '0;
    #1;
    chk_a("t3_drop_cycle", 4'd3, 1'b1, 16'h0008);
    step();
    chk_a("t3_idle", 4'd3, 1'b0, 16'h0);
    do_reset();

    ifa.req = 16'h8000;
    step();
    chk_a("t4_g15", 4'd15, 1'b1, 16'h8000);
    ifa.req = 16'h4001;
    step();
    chk_a("t4_wrap", 4'd0, 1'b1, 16'h0001);
    ifa.req = '0;
    do_reset();

    ifb.req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      step();
      chk($sformatf("t5_sel%0d", k), 16'(ifb.sel), 16'(k % 16));
      chk($sformatf("t5_vld%0d", k), 16'(ifb.sel_valid), 16'h1);
      chk($sformatf("t5_gnt%0d", k), ifb.grant, 16'(1) << (k % 16));
    end
    ifb.req = '0;
    do_reset();

    ifa.req = 16'h0010;
    step();
    step();
    chk_a("t6_pre", 4'd4, 1'b1, 16'h0010);
    #2 rst = 1'b1;
    #1;
    chk_a("t6_async", 4'd0, 1'b0, 16'h0);
    ifa.req = 16'h0030;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #1;
    chk_a("t6_released", 4'd0, 1'b0, 16'h0);
    step();
    chk_a("t6_regrant", 4'd4, 1'b1, 16'h0010);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) ifa.req = rnd_req();
      if ($urandom_range(0, 2) == 0) ifb.req = rnd_req();
      step();
      chk_model(0, $sformatf("rnd_a%0d", k));
      chk_model(1, $sformatf("rnd_b%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
